// File: rtl/fnd_scan_controller_pkg.sv
// Shared constants for the FND (7-segment) scan controller.
// Contents: active-low 7-seg pattern table for digits 0..9, BLANK code,
// digit count and the decimal-point blink thresholds.
package fnd_scan_controller_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Active-low segments, bit order g..a. Entry [n] is the pattern for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  localparam logic [6:0] BLANK = 7'h7F;

  // Decimal point blinks on for the first half of each unit.
  localparam int unsigned BLINK_MSEC_TH = 50;
  localparam int unsigned BLINK_SEC_TH  = 30;

endpackage

// File: rtl/fnd_scan_controller_time_splitter.sv
// Combinational decimal splitter: value -> ones and tens digits.
// Ports:
//   i_value : unsigned binary value
//   o_ones  : i_value % 10
//   o_tens  : i_value / 10 (may exceed 9 for out-of-range values)
module time_splitter #(
  parameter int unsigned BIT_WIDTH = 7
) (
  input  logic [BIT_WIDTH-1:0] i_value,
  output logic [BIT_WIDTH-1:0] o_ones,
  output logic [BIT_WIDTH-1:0] o_tens
);

  always_comb begin
    o_ones = i_value % BIT_WIDTH'(10);
    o_tens = i_value / BIT_WIDTH'(10);
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller.
// Shows sec.msec (i_sel_hm=0) or hour.min (i_sel_hm=1), one digit at a time.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   i_msec      : hundredths 0..99
//   i_sec       : seconds 0..59
//   i_min       : minutes 0..59
//   i_hour      : hours 0..23
//   i_sel_hm    : display select
//   o_fnd_com   : active-low digit enables, bit 0 = rightmost digit
//   o_fnd_data  : active-low segments, [6:0] = g..a, [7] = dp
module fnd_scan_controller
  import fnd_scan_controller_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ = 100_000_000,
  parameter int unsigned SCAN_HZ    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  input  logic       i_sel_hm,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_data
);

  localparam int unsigned DIV    = SYS_CLK_HZ / SCAN_HZ;
  localparam int unsigned TCNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

  logic [TCNT_W-1:0] r_tcnt;
  logic [IDX_W-1:0]  r_idx;
  logic [3:0]        r_com;
  logic [7:0]        r_data;

  logic       w_tick;
  logic [6:0] w_low;
  logic [6:0] w_high;
  logic [6:0] w_value;
  logic [6:0] w_ones;
  logic [6:0] w_tens;
  logic [6:0] w_digit;
  logic       w_blink;
  logic       w_dp_on;

  function automatic logic [6:0] f_decode(input logic [6:0] value);
    if (value < 7'd10) begin
      return SEG_TABLE[value[3:0]];
    end
    return BLANK;
  endfunction

  assign w_tick = (r_tcnt == TCNT_W'(DIV - 1));

  // Low/high display fields, zero-extended to the splitter width.
  assign w_low  = i_sel_hm ? {1'b0, i_min}  : i_msec;
  assign w_high = i_sel_hm ? {2'b0, i_hour} : {1'b0, i_sec};

  // idx[1] picks the field, idx[0] picks tens over ones.
  assign w_value = r_idx[1] ? w_high : w_low;
  assign w_digit = r_idx[0] ? w_tens : w_ones;

  time_splitter #(
    .BIT_WIDTH(7)
  ) u_time_splitter (
    .i_value(w_value),
    .o_ones (w_ones),
    .o_tens (w_tens)
  );

  assign w_blink = i_sel_hm ? (i_sec < 6'(BLINK_SEC_TH)) : (i_msec < 7'(BLINK_MSEC_TH));
  assign w_dp_on = (r_idx == IDX_W'(2)) && w_blink;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
      r_idx  <= '0;
      r_com  <= 4'hF;
      r_data <= 8'hFF;
    end else begin
      if (w_tick) begin
        r_tcnt <= '0;
        r_idx  <= r_idx + IDX_W'(1);
      end else begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end
      // Outputs track the idx held before this edge, so they lag idx by one clk.
      r_com  <= ~(4'b0001 << r_idx);
      r_data <= {~w_dp_on, f_decode(w_digit)};
    end
  end

  assign o_fnd_com  = r_com;
  assign o_fnd_data = r_data;

endmodule
